// File: rtl/bp_pkg.sv
// bp_pkg: shared gshare predictor types: 2-bit counter + SNT/WNT/WT/ST, pcsrcd encodings, BTB entry struct, counter step helper
package bp_pkg;
  localparam int ADDR_MAX = 32;
  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;
  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_JMP = 2'b10;
  localparam logic [1:0] SRC_ILL = 2'b11;
  typedef struct packed {
    logic                valid;
    logic                jump;
    logic [ADDR_MAX-1:0] tag;
    logic [ADDR_MAX-1:0] target;
  } btb_entry_t;
  function automatic ctr_t ctr_next(input ctr_t c, input logic up);
    return up ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/btb_cam.sv
// btb_cam: fully associative BTB; fetch port fkey->fhit/fjump/ftarget, decode port dkey with write we/wjump/wtarget (overwrite on hit, else round-robin allocate)
module btb_cam
  import bp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fkey,
  output logic             fhit,
  output logic             fjump,
  output logic [WIDTH-1:0] ftarget,
  input  logic [WIDTH-1:0] dkey,
  input  logic             we,
  input  logic             wjump,
  input  logic [WIDTH-1:0] wtarget
);
  localparam int PW = $clog2(ENTRIES);
  btb_entry_t mem [ENTRIES];
  logic [PW-1:0] ptr, dsel;
  logic dhit;
  always_comb begin
    fhit = 1'b0;
    fjump = 1'b0;
    ftarget = '0;
    dhit = 1'b0;
    dsel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (mem[i].valid && mem[i].tag == ADDR_MAX'(fkey)) begin
        fhit = 1'b1;
        fjump = mem[i].jump;
        ftarget = WIDTH'(mem[i].target);
      end
      if (mem[i].valid && mem[i].tag == ADDR_MAX'(dkey)) begin
        dhit = 1'b1;
        dsel = PW'(i);
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (we) begin
      mem[dhit ? dsel : ptr] <= '{valid: 1'b1, jump: wjump, tag: ADDR_MAX'(dkey), target: ADDR_MAX'(wtarget)};
      if (!dhit) ptr <= ptr == PW'(ENTRIES - 1) ? '0 : ptr + 1'b1;
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: BTB + gshare PHT fetch predictor; in originalpc/pcd/pcbranchd/pcsrcd/branchd/stalld, out pcnext (next fetch PC) and clrbp (mispredict flush)
module gshare_branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 8,
  parameter int GHR_BITS = 4,
  parameter int PC_INC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] originalpc,
  input  logic [WIDTH-1:0] pcd,
  input  logic [WIDTH-1:0] pcbranchd,
  input  logic [1:0]       pcsrcd,
  input  logic             branchd,
  input  logic             stalld,
  output logic [WIDTH-1:0] pcnext,
  output logic             clrbp
);
  ctr_t pht [1 << GHR_BITS];
  logic [GHR_BITS-1:0] ghr, idx, s_idx;
  logic s_valid, s_taken, fhit, fjump, predtaken, chk, act;
  logic [WIDTH-1:0] ftarget, s_target, cpc;
  assign idx = originalpc[GHR_BITS-1:0] ^ ghr;
  // reset gating keeps outputs clean while storage is still being cleared
  assign predtaken = ~reset & fhit & (fjump | pht[idx][1]);
  assign chk = ~reset & s_valid & ~stalld;
  assign act = pcsrcd != SRC_SEQ;
  assign clrbp = chk & ((s_taken != act) | (s_taken & act & (s_target != pcbranchd)));
  assign cpc = act ? pcbranchd : pcd + WIDTH'(PC_INC);
  assign pcnext = clrbp ? cpc : predtaken ? ftarget : originalpc;
  btb_cam #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) u_btb (
    .clk,
    .reset,
    .fkey(originalpc),
    .fhit,
    .fjump,
    .ftarget,
    .dkey(pcd),
    .we(chk & act),
    .wjump(pcsrcd inside {SRC_JMP, SRC_ILL}),
    .wtarget(pcbranchd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      s_valid <= 1'b0;
      ghr <= '0;
      for (int i = 0; i < (1 << GHR_BITS); i++) pht[i] <= WNT;
    end else if (!stalld) begin
      s_valid <= ~clrbp;
      s_taken <= predtaken;
      s_target <= ftarget;
      s_idx <= idx;
      if (chk & branchd) begin
        pht[s_idx] <= ctr_next(pht[s_idx], act);
        ghr <= {ghr[GHR_BITS-2:0], act};
      end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: directed scoreboard bench for the gshare predictor with a 2-entry BTB
module tb_gshare_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] originalpc, pcd, pcbranchd, pcnext;
  logic [1:0] pcsrcd;
  logic branchd, stalld, clrbp;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    string tag;
    logic [31:0] pc;
    logic clr;
  } exp_t;
  exp_t sb [$];
  always #5 clk = ~clk;
  gshare_branch_predictor #(.WIDTH(32), .ENTRIES(2), .GHR_BITS(4), .PC_INC(4)) dut (
    .clk(clk),
    .reset(reset),
    .originalpc(originalpc),
    .pcd(pcd),
    .pcbranchd(pcbranchd),
    .pcsrcd(pcsrcd),
    .branchd(branchd),
    .stalld(stalld),
    .pcnext(pcnext),
    .clrbp(clrbp)
  );
  task automatic step(input string tag, input logic rs, input logic [31:0] o, input logic [31:0] pd,
                      input logic [31:0] pb, input logic [1:0] src, input logic br, input logic stl,
                      input logic [31:0] epc, input logic eclr);
    exp_t e;
    reset = rs;
    originalpc = o;
    pcd = pd;
    pcbranchd = pb;
    pcsrcd = src;
    branchd = br;
    stalld = stl;
    sb.push_back('{tag, epc, eclr});
    @(negedge clk);
    e = sb.pop_front();
    nvec++;
    assert (pcnext === e.pc) else begin
      nerr++;
      $error("FAIL %s pcnext got %h expected %h", e.tag, pcnext, e.pc);
    end
    nvec++;
    assert (clrbp === e.clr) else begin
      nerr++;
      $error("FAIL %s clrbp got %b expected %b", e.tag, clrbp, e.clr);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input string tag, input logic [31:0] o, input logic [31:0] epc);
    step(tag, 1'b0, o, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, epc, 1'b0);
  endtask
  initial begin
    reset = 1'b1;
    originalpc = 32'h10;
    pcd = '0;
    pcbranchd = '0;
    pcsrcd = 2'b00;
    branchd = 1'b0;
    stalld = 1'b0;
    @(posedge clk);
    #1;
    step("rst", 1'b1, 32'h10, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h10, 1'b0);
    step("rst", 1'b1, 32'h10, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) idle("idle", 32'h10, 32'h10);
    idle("cold_miss", 32'h20, 32'h20);
    step("cold_flush", 1'b0, 32'h24, 32'h20, 32'h100, 2'b10, 1'b0, 1'b0, 32'h100, 1'b1);
    idle("jmp_hit", 32'h20, 32'h100);
    step("jmp_ok", 1'b0, 32'h100, 32'h20, 32'h100, 2'b10, 1'b0, 1'b0, 32'h100, 1'b0);
    idle("wt_hit", 32'h20, 32'h100);
    step("wt_flush", 1'b0, 32'h100, 32'h20, 32'h200, 2'b10, 1'b0, 1'b0, 32'h200, 1'b1);
    idle("wt_squash", 32'h200, 32'h200);
    idle("wt_new", 32'h20, 32'h200);
    step("wt_ok", 1'b0, 32'h200, 32'h20, 32'h200, 2'b10, 1'b0, 1'b0, 32'h200, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle("tr_fetch", 32'h10, 32'h10);
      step("tr_mis", 1'b0, 32'h14, 32'h10, 32'h80, 2'b01, 1'b1, 1'b0, 32'h80, 1'b1);
    end
    idle("tr_fetch6", 32'h10, 32'h80);
    step("tr_ok", 1'b0, 32'h80, 32'h10, 32'h80, 2'b01, 1'b1, 1'b0, 32'h80, 1'b0);
    idle("sat_fetch", 32'h10, 32'h80);
    step("nt_flush", 1'b0, 32'h80, 32'h10, 32'h80, 2'b00, 1'b1, 1'b0, 32'h14, 1'b1);
    idle("ghr_fetch", 32'h10, 32'h10);
    idle("rp_hit", 32'h20, 32'h200);
    step("rp_rst", 1'b1, 32'h30, 32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 32'h30, 1'b0);
    step("rp_after", 1'b0, 32'h30, 32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 32'h30, 1'b0);
    for (int k = 2; k < 5; k++) begin
      logic [31:0] pc;
      pc = 32'(k) << 4;
      idle("al_miss", pc, pc);
      step("al_flush", 1'b0, pc + 32'h4, pc, pc + 32'h100, 2'b10, 1'b0, 1'b0, pc + 32'h100, 1'b1);
    end
    idle("ev_20", 32'h20, 32'h20);
    idle("hit_30", 32'h30, 32'h130);
    step("hit_40", 1'b0, 32'h40, 32'h30, 32'h130, 2'b10, 1'b0, 1'b0, 32'h140, 1'b0);
    step("ok_40", 1'b0, 32'h140, 32'h40, 32'h140, 2'b10, 1'b0, 1'b0, 32'h140, 1'b0);
    step("sq_flush", 1'b0, 32'h60, 32'h60, 32'h160, 2'b10, 1'b0, 1'b0, 32'h160, 1'b1);
    step("sq_skip", 1'b0, 32'h164, 32'h50, 32'h250, 2'b01, 1'b1, 1'b0, 32'h164, 1'b0);
    idle("sq_noalloc", 32'h50, 32'h50);
    idle("st_fetch", 32'h40, 32'h140);
    for (int k = 0; k < 3; k++)
      step("st_hold", 1'b0, 32'h20, 32'h70, 32'h0, 2'b00, 1'b0, 1'b1, 32'h20, 1'b0);
    step("st_check", 1'b0, 32'h140, 32'h40, 32'h0, 2'b00, 1'b0, 1'b0, 32'h44, 1'b1);
    step("st_once", 1'b0, 32'h44, 32'h40, 32'h0, 2'b00, 1'b0, 1'b0, 32'h44, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
